// File: rtl/gcd_requester.sv
// gcd_requester: queues operand pairs, issues them one at a time to a gcd core and
// returns results in request order; a watchdog answers with an error if the core stalls.
// Optional accepted-response counters are enabled by defining GCD_REQUESTER_STATS_EN.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             gcd_valid_o,
  output logic [WIDTH-1:0] gcd_a_o,
  output logic [WIDTH-1:0] gcd_b_o,
  input  logic             gcd_valid_i,
  input  logic [WIDTH-1:0] gcd_result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_gcd_o,
  output logic             res_err_o
`ifdef GCD_REQUESTER_STATS_EN
  ,
  output logic [15:0]      stat_done_o,
  output logic [15:0]      stat_timeout_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP, S_RECOVER
  } state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             r_ready;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_res_gcd;
  logic             r_res_err;
  logic [WD_W-1:0]  r_wd;
  logic             w_push, w_pop, w_wd_hit;

  assign w_push       = req_valid_i && r_ready;
  assign w_pop        = (r_state == S_ISSUE);
  assign w_wd_hit     = (r_wd == WD_W'(TIMEOUT - 1));
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: the storage array carries no reset; pointers and count alone say what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= req_a_i;
      r_mem_b[r_wr_ptr] <= req_b_i;
    end
  end

  // NOTE: next state has a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_count != '0) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = S_WAIT;
      S_WAIT:    if (gcd_valid_i || w_wd_hit) w_state_next = S_RESP;
      // An error response means the core may still answer late, so drain it in RECOVER.
      S_RESP:    if (res_ready_i) w_state_next = r_res_err ? S_RECOVER : S_GAP;
      S_GAP:     w_state_next = S_IDLE;
      S_RECOVER: if (gcd_valid_i || w_wd_hit) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_res_gcd <= '0;
      r_res_err <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_op_a   <= r_mem_a[r_rd_ptr];
        r_op_b   <= r_mem_b[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Counting from the start pulse makes the error response land TIMEOUT cycles after it.
      if (r_state inside {S_ISSUE, S_WAIT, S_RECOVER}) r_wd <= r_wd + 1'b1;
      else                                             r_wd <= '0;
      if (r_state == S_WAIT) begin
        if (gcd_valid_i) begin
          r_res_gcd <= gcd_result_i;
          r_res_err <= 1'b0;
        end else if (w_wd_hit) begin
          r_res_gcd <= '0;
          r_res_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o = r_ready;
  assign gcd_valid_o = (r_state == S_ISSUE);
  assign gcd_a_o     = r_op_a;
  assign gcd_b_o     = r_op_b;
  assign res_valid_o = (r_state == S_RESP);
  assign res_gcd_o   = r_res_gcd;
  assign res_err_o   = r_res_err;

`ifdef GCD_REQUESTER_STATS_EN
  logic        w_accept;
  logic [15:0] r_stat_done, r_stat_timeout;

  assign w_accept = (r_state == S_RESP) && res_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stat_done    <= '0;
      r_stat_timeout <= '0;
    end else if (w_accept) begin
      if (r_res_err) begin
        if (r_stat_timeout != 16'hFFFF) r_stat_timeout <= r_stat_timeout + 16'd1;
      end else begin
        if (r_stat_done != 16'hFFFF) r_stat_done <= r_stat_done + 16'd1;
      end
    end
  end

  assign stat_done_o    = r_stat_done;
  assign stat_timeout_o = r_stat_timeout;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: a behavioural gcd core answers start pulses after a fixed
// latency; a scoreboard queue holds expected responses in request order.
module tb_gcd_requester;

  localparam int WIDTH        = 8;
  localparam int DEPTH        = 4;
  localparam int TIMEOUT      = 16;
  localparam int CORE_L       = 3;           // operand capture to result pulse
  localparam int START_TO_RES = CORE_L + 1;  // start pulse to result pulse

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] g;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_a_i, req_b_i;
  logic             gcd_valid_o;
  logic [WIDTH-1:0] gcd_a_o, gcd_b_o;
  logic             gcd_valid_i;
  logic [WIDTH-1:0] gcd_result_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_gcd_o;
  logic             res_err_o;
`ifdef GCD_REQUESTER_STATS_EN
  logic [15:0]      stat_done_o, stat_timeout_o;
`endif

  vec_t vecs [15];
  exp_t exp_q [$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int starts = 0, last_start = 0, res_cycles = 0, n_ok_acc = 0, n_err_acc = 0;

  logic       mute = 1'b0, stray_vld = 1'b0, core_vld = 1'b0;
  logic       core_busy = 1'b0, cap_pend = 1'b0;
  logic [7:0] core_res = '0, cap_a = '0, cap_b = '0;
  int         core_cnt = 0;

  assign gcd_valid_i  = core_vld | stray_vld;
  assign gcd_result_i = stray_vld ? 8'hEE : core_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .gcd_valid_o  (gcd_valid_o),
    .gcd_a_o      (gcd_a_o),
    .gcd_b_o      (gcd_b_o),
    .gcd_valid_i  (gcd_valid_i),
    .gcd_result_i (gcd_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_gcd_o    (res_gcd_o),
    .res_err_o    (res_err_o)
`ifdef GCD_REQUESTER_STATS_EN
    ,
    .stat_done_o    (stat_done_o),
    .stat_timeout_o (stat_timeout_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: samples operands the cycle after the start pulse, pulses the result later.
  always @(negedge clk) begin
    if (!rst_ni) begin
      core_vld  <= 1'b0;
      core_busy <= 1'b0;
      cap_pend  <= 1'b0;
      core_cnt  <= 0;
    end else begin
      core_vld <= 1'b0;
      if (cap_pend) begin
        cap_pend  <= 1'b0;
        cap_a     <= gcd_a_o;
        cap_b     <= gcd_b_o;
        core_res  <= ref_gcd(gcd_a_o, gcd_b_o);
        core_busy <= 1'b1;
        core_cnt  <= CORE_L;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_vld  <= 1'b1;
          core_busy <= 1'b0;
          check("gcd_a_held", gcd_a_o, cap_a);
          check("gcd_b_held", gcd_b_o, cap_b);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (gcd_valid_o && !mute) begin
        check("core_idle_at_start", core_busy | cap_pend | core_vld, 0);
        cap_pend <= 1'b1;
      end
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst_ni) begin
      n_ok_acc  <= 0;
      n_err_acc <= 0;
    end else begin
      if (gcd_valid_o) begin
        if (starts > 0) check("start_spacing", (cyc - last_start) >= START_TO_RES + 2, 1);
        starts     <= starts + 1;
        last_start <= cyc;
      end
      if (res_valid_o) res_cycles <= res_cycles + 1;
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", res_gcd_o, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_gcd", res_gcd_o, e.g);
          check("res_err", res_err_o, e.err);
        end
        if (res_err_o) n_err_acc <= n_err_acc + 1;
        else           n_ok_acc  <= n_ok_acc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input vec_t v);
    bit ok = 1'b0;
    req_valid_i = 1'b1;
    req_a_i     = v.a;
    req_b_i     = v.b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready_o) ok = 1'b1;
    end
    check("push_accepted", ok, 1);
    if (ok) exp_q.push_back('{g: v.g, err: v.err});
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check({"drain_", tag}, exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 0);
    check({tag, "_gcd_valid"}, gcd_valid_o, 0);
    check({tag, "_gcd_a"},     gcd_a_o, 0);
    check({tag, "_gcd_b"},     gcd_b_o, 0);
    check({tag, "_res_valid"}, res_valid_o, 0);
    check({tag, "_res_gcd"},   res_gcd_o, 0);
    check({tag, "_res_err"},   res_err_o, 0);
  endtask

  task automatic wait_start(output int at, output bit seen);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (gcd_valid_o) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  initial begin
    int s0, r0, acc, sc, t_start;
    bit seen;

    vecs[0]  = '{8'd18,  8'd12, 8'd6, 1'b0};
    vecs[1]  = '{8'd6,   8'd2,  8'd2, 1'b0};
    vecs[2]  = '{8'd9,   8'd12, 8'd3, 1'b0};
    vecs[3]  = '{8'd18,  8'd12, 8'd6, 1'b0};
    vecs[4]  = '{8'd0,   8'd7,  8'd7, 1'b0};
    vecs[5]  = '{8'd255, 8'd1,  8'd1, 1'b0};
    vecs[6]  = '{8'd9,   8'd12, 8'd3, 1'b0};
    vecs[7]  = '{8'd18,  8'd12, 8'd6, 1'b0};
    vecs[8]  = '{8'd12,  8'd8,  8'd0, 1'b1};
    vecs[9]  = '{8'd7,   8'd21, 8'd7, 1'b0};
    vecs[10] = '{8'd4,   8'd6,  8'd2, 1'b0};
    vecs[11] = '{8'd10,  8'd15, 8'd5, 1'b0};
    vecs[12] = '{8'd14,  8'd21, 8'd7, 1'b0};
    vecs[13] = '{8'd8,   8'd12, 8'd4, 1'b0};
    vecs[14] = '{8'd21,  8'd14, 8'd7, 1'b0};

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_a_i     = '0;
    req_b_i     = '0;
    res_ready_i = 1'b1;

    // Reset state and release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    tick();
    rst_ni = 1'b1;
    tick();
    @(negedge clk);
    check("ready_after_release", req_ready_o, 1);
    tick();

    // Single request.
    s0 = starts;
    r0 = res_cycles;
    push_req(vecs[0]);
    drain("single");
    check("single_one_start", starts - s0, 1);
    check("single_one_res_cycle", res_cycles - r0, 1);

    // Burst of five: the FIFO fills while the first request is in flight.
    for (int i = 1; i <= 5; i++) push_req(vecs[i]);
    @(negedge clk);
    check("burst_full_ready_low", req_ready_o, 0);
    tick();
    drain("burst");
    @(negedge clk);
    check("burst_ready_back", req_ready_o, 1);
    tick();

    // Backpressure on the response.
    res_ready_i = 1'b0;
    push_req(vecs[6]);
    push_req(vecs[7]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid_o;
    end
    check("bp_response_seen", seen, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid_hold", res_valid_o, 1);
      check("bp_gcd_hold", res_gcd_o, 3);
      check("bp_no_issue", gcd_valid_o, 0);
    end
    tick();
    res_ready_i = 1'b1;
    @(negedge clk);
    acc = cyc;
    wait_start(t_start, seen);
    check("bp_next_start_seen", seen, 1);
    check("bp_accept_to_issue", t_start - acc, 3);
    tick();
    drain("backpressure");

    // Timeout, then a stray late pulse during recovery, then a normal request.
    mute = 1'b1;
    push_req(vecs[8]);
    push_req(vecs[9]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid_o;
    end
    check("to_response_seen", seen, 1);
    check("to_latency", cyc - last_start, TIMEOUT);
    check("to_err_flag", res_err_o, 1);
    check("to_gcd_zero", res_gcd_o, 0);
    tick();
    mute = 1'b0;
    repeat (2) tick();
    stray_vld = 1'b1;
    @(negedge clk);
    sc = cyc;
    tick();
    stray_vld = 1'b0;
    wait_start(t_start, seen);
    check("recover_next_start_seen", seen, 1);
    check("recover_stray_to_issue", t_start - sc, 2);
    tick();
    drain("timeout");

`ifdef GCD_REQUESTER_STATS_EN
    check("stat_done", stat_done_o, n_ok_acc);
    check("stat_timeout", stat_timeout_o, n_err_acc);
    check("stat_timeout_seen", stat_timeout_o, 1);
`endif

    // Reset while waiting on the core with three requests queued.
    mute = 1'b1;
    for (int i = 10; i <= 13; i++) push_req(vecs[i]);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    exp_q.delete();
    tick();
    s0 = starts;
    r0 = res_cycles;
    repeat (40) tick();
    check("flush_no_issue", starts - s0, 0);
    check("flush_no_response", res_cycles - r0, 0);
    mute = 1'b0;
    push_req(vecs[14]);
    drain("after_reset");

`ifdef GCD_REQUESTER_STATS_EN
    check("stat_done_after_reset", stat_done_o, n_ok_acc);
    check("stat_timeout_after_reset", stat_timeout_o, n_err_acc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench time limit exceeded");
  end

endmodule
